button_event_gen: RTL and testbench

//  Consumes the debounced push-button level from the debouncer stage (same clk) and converts it

---
 rtl/btn_pkg.sv | 23 ++
 rtl/cycle_timer.sv | 28 ++
 rtl/button_event_gen.sv | 121 ++++++++++++
 tb/tb_button_event_gen.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for debounced-input blocks: state encoding and counter sizing.
package btn_pkg;

  localparam logic [1:0] ST_LOCK   = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_PRESS  = 2'd2;
  localparam logic [1:0] ST_REPEAT = 2'd3;

  typedef enum logic [1:0] {
    LOCK   = ST_LOCK,
    IDLE   = ST_IDLE,
    PRESS  = ST_PRESS,
    REPEAT = ST_REPEAT
  } btn_state_t;

  // Width needed to count up to max(a,b)-1, never less than one bit.
  function automatic int unsigned widthFor(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Free-running cycle counter that wraps to zero on reaching a selectable terminal value.
module cycle_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic [W-1:0] i_terminal,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  assign o_done = (r_cnt == i_terminal);

  // Wrapping on terminal keeps the count bounded and restarts the next interval immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= o_done ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/button_event_gen.sv
// Turns a debounced button level into registered press/release/long/repeat strobes.
module button_event_gen
  import btn_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned COUNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_level,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               long_pulse,
  output logic               repeat_pulse,
  output logic               step,
  output logic               held,
  output logic [COUNT_W-1:0] press_count
);

  localparam int unsigned CNT_W = widthFor(HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_TERM   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

  btn_state_t       r_state;
  btn_state_t       w_nextState;
  logic             w_press;
  logic             w_release;
  logic             w_long;
  logic             w_repeat;
  logic             w_clear;
  logic             w_enable;
  logic             w_done;
  logic [CNT_W-1:0] w_terminal;

  assign w_terminal = (r_state == REPEAT) ? REPEAT_TERM : HOLD_TERM;

  cycle_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_clear),
    .i_enable   (w_enable),
    .i_terminal (w_terminal),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= LOCK;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Release is checked before the terminal count so it wins when both land on one edge.
  always_comb begin
    w_nextState = r_state;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_long      = 1'b0;
    w_repeat    = 1'b0;
    w_clear     = 1'b0;
    w_enable    = 1'b0;
    case (r_state)
      LOCK: begin
        w_clear = 1'b1;
        if (!btn_level) w_nextState = IDLE;
      end
      IDLE: begin
        w_clear = 1'b1;
        if (btn_level) begin
          w_nextState = PRESS;
          w_press     = 1'b1;
        end
      end
      PRESS: begin
        if (!btn_level) begin
          w_nextState = IDLE;
          w_release   = 1'b1;
        end else begin
          w_enable = 1'b1;
          if (w_done) begin
            w_nextState = REPEAT;
            w_long      = 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!btn_level) begin
          w_nextState = IDLE;
          w_release   = 1'b1;
        end else begin
          w_enable = 1'b1;
          w_repeat = w_done;
        end
      end
      default: w_nextState = LOCK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      step          <= 1'b0;
      held          <= 1'b0;
      press_count   <= '0;
    end else begin
      press_pulse   <= w_press;
      release_pulse <= w_release;
      long_pulse    <= w_long;
      repeat_pulse  <= w_repeat;
      step          <= w_press | w_long | w_repeat;
      held          <= (w_nextState == PRESS) || (w_nextState == REPEAT);
      if (w_press) press_count <= press_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed self-checking bench for button_event_gen with short hold/repeat intervals.
module tb_button_event_gen;
  import btn_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       btnLevel;
  logic       pressPulse;
  logic       releasePulse;
  logic       longPulse;
  logic       repeatPulse;
  logic       step;
  logic       held;
  logic [7:0] pressCount;

  int checkCount;
  int failCount;
  int pressSeen;
  int releaseSeen;
  int longSeen;
  int repeatSeen;
  int stepSeen;

  button_event_gen #(
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4),
    .COUNT_W       (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_level     (btnLevel),
    .press_pulse   (pressPulse),
    .release_pulse (releasePulse),
    .long_pulse    (longPulse),
    .repeat_pulse  (repeatPulse),
    .step          (step),
    .held          (held),
    .press_count   (pressCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally strobes mid-cycle so whole phases can be checked by event totals.
  always @(negedge clk) begin
    if (pressPulse)   pressSeen++;
    if (releasePulse) releaseSeen++;
    if (longPulse)    longSeen++;
    if (repeatPulse)  repeatSeen++;
    if (step)         stepSeen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic btn, input int cycles);
    btnLevel = btn;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".outs"},
                {24'd0, pressPulse, releasePulse, longPulse, repeatPulse, step, held, 2'd0}, 32'd0);
    checkOutput({tag, ".count"}, 32'(pressCount), 32'd0);
  endtask

  initial begin
    int pressBase;
    int releaseBase;
    int longBase;
    int repeatBase;
    int stepBase;
    logic expLong;
    logic expRepeat;

    checkCount  = 0;
    failCount   = 0;
    pressSeen   = 0;
    releaseSeen = 0;
    longSeen    = 0;
    repeatSeen  = 0;
    stepSeen    = 0;
    btnLevel    = 1'b1;
    rst_n       = 1'b1;
    #1 rst_n    = 1'b0;

    // Test 1: button held through reset is locked out until released.
    applyStimulus(1'b1, 3);
    checkAllZero("t1.reset");
    checkOutput("t1.state", 32'(dut.r_state), 32'(ST_LOCK));
    rst_n = 1'b1;
    pressBase = pressSeen;
    stepBase  = stepSeen;
    applyStimulus(1'b1, 10);
    checkOutput("t1.heldNoPress", 32'(pressSeen - pressBase), 32'd0);
    checkOutput("t1.heldNoStep", 32'(stepSeen - stepBase), 32'd0);
    checkOutput("t1.heldLow", 32'(held), 32'd0);
    releaseBase = releaseSeen;
    applyStimulus(1'b0, 2);
    checkOutput("t1.dropNoRelease", 32'(releaseSeen - releaseBase), 32'd0);
    applyStimulus(1'b1, 1);
    checkOutput("t1.press", 32'(pressPulse), 32'd1);
    checkOutput("t1.step", 32'(step), 32'd1);
    checkOutput("t1.count", 32'(pressCount), 32'd1);
    applyStimulus(1'b1, 1);
    checkOutput("t1.pressOneCycle", 32'(pressPulse), 32'd0);
    checkOutput("t1.stepOneCycle", 32'(step), 32'd0);
    applyStimulus(1'b0, 1);
    checkOutput("t1.release", 32'(releasePulse), 32'd1);
    applyStimulus(1'b0, 2);

    // Test 2: short press of three high samples.
    longBase = longSeen;
    applyStimulus(1'b1, 1);
    checkOutput("t2.press", 32'(pressPulse), 32'd1);
    checkOutput("t2.held0", 32'(held), 32'd1);
    applyStimulus(1'b1, 1);
    checkOutput("t2.held1", 32'(held), 32'd1);
    applyStimulus(1'b1, 1);
    checkOutput("t2.held2", 32'(held), 32'd1);
    checkOutput("t2.noRelYet", 32'(releasePulse), 32'd0);
    applyStimulus(1'b0, 1);
    checkOutput("t2.release", 32'(releasePulse), 32'd1);
    checkOutput("t2.heldOff", 32'(held), 32'd0);
    applyStimulus(1'b0, 1);
    checkOutput("t2.releaseOneCycle", 32'(releasePulse), 32'd0);
    checkOutput("t2.noLong", 32'(longSeen - longBase), 32'd0);
    checkOutput("t2.count", 32'(pressCount), 32'd2);

    // Test 3: long hold; long at E0+8, repeats at E0+12 and E0+16, release at E0+20.
    stepBase   = stepSeen;
    repeatBase = repeatSeen;
    applyStimulus(1'b1, 1);
    checkOutput("t3.press", 32'(pressPulse), 32'd1);
    for (int k = 1; k < 20; k++) begin
      applyStimulus(1'b1, 1);
      expLong   = (k == 8);
      expRepeat = (k == 12) || (k == 16);
      checkOutput($sformatf("t3.long@%0d", k), 32'(longPulse), 32'(expLong));
      checkOutput($sformatf("t3.repeat@%0d", k), 32'(repeatPulse), 32'(expRepeat));
      checkOutput($sformatf("t3.step@%0d", k), 32'(step), 32'(expLong | expRepeat));
    end
    applyStimulus(1'b0, 1);
    checkOutput("t3.release", 32'(releasePulse), 32'd1);
    checkOutput("t3.noRepeatOnRelease", 32'(repeatPulse), 32'd0);
    checkOutput("t3.noStepOnRelease", 32'(step), 32'd0);
    applyStimulus(1'b0, 2);
    checkOutput("t3.stepTotal", 32'(stepSeen - stepBase), 32'd4);
    checkOutput("t3.repeatTotal", 32'(repeatSeen - repeatBase), 32'd2);
    checkOutput("t3.count", 32'(pressCount), 32'd3);

    // Test 4: 256 short presses wrap the counter back to its starting value.
    pressBase   = pressSeen;
    releaseBase = releaseSeen;
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 1);
      if (i == 252) checkOutput("t4.wrapZero", 32'(pressCount), 32'd0);
      applyStimulus(1'b0, 2);
    end
    checkOutput("t4.presses", 32'(pressSeen - pressBase), 32'd256);
    checkOutput("t4.releases", 32'(releaseSeen - releaseBase), 32'd256);
    checkOutput("t4.count", 32'(pressCount), 32'd3);

    // Test 5: reset asserted in REPEAT one cycle before a repeat is due.
    applyStimulus(1'b1, 16);
    checkOutput("t5.inRepeat", 32'(dut.r_state), 32'(ST_REPEAT));
    rst_n = 1'b0;
    #1;
    checkAllZero("t5.asyncReset");
    checkOutput("t5.state", 32'(dut.r_state), 32'(ST_LOCK));
    applyStimulus(1'b1, 2);
    checkAllZero("t5.heldReset");
    rst_n = 1'b1;
    pressBase = pressSeen;
    stepBase  = stepSeen;
    applyStimulus(1'b1, 6);
    checkOutput("t5.lockedPress", 32'(pressSeen - pressBase), 32'd0);
    checkOutput("t5.lockedStep", 32'(stepSeen - stepBase), 32'd0);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 1);
    checkOutput("t5.press", 32'(pressPulse), 32'd1);
    checkOutput("t5.count", 32'(pressCount), 32'd1);
    applyStimulus(1'b1, 2);
    checkOutput("t5.held", 32'(held), 32'd1);
    applyStimulus(1'b0, 1);
    checkOutput("t5.release", 32'(releasePulse), 32'd1);
    checkOutput("t5.heldOff", 32'(held), 32'd0);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
